// File: rtl/pkfb_packetizer.sv
// pkfb_packetizer: frames a 32-bit valid/ready sample stream into fixed-length
// packets for the ASSP packet FIFO push interface (FB_PKfb*). On overflow of a
// pushed word the rest of that packet is swallowed and counted in drop_cnt,
// so the FIFO never holds a silently truncated frame.
//
// Optional build macro PKFB_TIMESTAMP_EN: prepends a header word
// {seq[7:0], TimeStamp[23:0]} to every packet and adds the TimeStamp input.
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | between packets; next accepted word (or header) opens a frame
//   HDR     | header word is on the bus; data words not yet started
//           | (PKFB_TIMESTAMP_EN builds only)
//   ACTIVE  | mid-packet, data words are being pushed
//   DISCARD | overflow hit mid-packet; remaining words accepted and dropped

module pkfb_packetizer #(
    parameter int PKT_LEN = 64,
    parameter int PUSH_CH = 0
) (
    input  logic        Sys_PKfb_Clk,
    input  logic        Sys_PKfb_Rst_n,
    input  logic        enable,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [31:0] FB_PKfbData,
    output logic [3:0]  FB_PKfbPush,
    output logic        FB_PKfbSOF,
    output logic        FB_PKfbEOF,
    input  logic        FB_PKfbOverflow,
`ifdef PKFB_TIMESTAMP_EN
    input  logic [23:0] TimeStamp,
`endif
    input  logic        ovf_clr,
    output logic        ovf_sticky,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;
`ifdef PKFB_TIMESTAMP_EN
    localparam logic [1:0] HDR     = 2'd3;
`endif

    // Index of the last data word of a frame; a 1-word frame opens and closes at once.
    localparam logic [15:0] LAST      = 16'(PKT_LEN - 1);
    localparam logic        SINGLE    = (PKT_LEN == 1);
    localparam logic [3:0]  PUSH_MASK = 4'(1 << PUSH_CH);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  eff_state;
    logic [15:0] word_cnt;
    logic [15:0] cnt_nxt;

    logic        push_q;
    logic        sof_q;
    logic        eof_q;
    logic [31:0] data_q;
    logic        push_nxt;
    logic        sof_nxt;
    logic        eof_nxt;
    logic [31:0] data_nxt;

`ifdef PKFB_TIMESTAMP_EN
    logic [7:0]  seq;
    logic [7:0]  seq_nxt;
`endif

    logic        accept;
    logic        ovf_hit;
    logic        is_last;
    logic        discard_acc;
    logic [16:0] drop_sum;

    assign FB_PKfbData = data_q;
    assign FB_PKfbPush = push_q ? PUSH_MASK : 4'b0000;
    assign FB_PKfbSOF  = sof_q;
    assign FB_PKfbEOF  = eof_q;

    // Overflow only means something while our own push is on the bus.
    assign ovf_hit = push_q & FB_PKfbOverflow;
    assign accept  = s_valid & s_ready;
    assign is_last = (word_cnt == LAST);

    // Ready depends only on the registered state, so there is no path from
    // FB_PKfbOverflow to s_ready.
    always_comb begin
        s_ready = 1'b1;
        if (state == IDLE) begin
`ifdef PKFB_TIMESTAMP_EN
            s_ready = 1'b0;
`else
            s_ready = enable;
`endif
        end
    end

    // An overflow on a non-final word redirects this cycle's accept into
    // DISCARD, since that word was accepted before the overflow was known.
    always_comb begin
        eff_state = state;
        if (ovf_hit && !eof_q) begin
            eff_state = DISCARD;
        end
    end

    assign discard_acc = accept & (eff_state == DISCARD);
    assign drop_sum    = {1'b0, drop_cnt} + {16'd0, ovf_hit} + {16'd0, discard_acc};

    // Next-state, word count and next registered FIFO-side outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = word_cnt;
        push_nxt  = 1'b0;
        sof_nxt   = 1'b0;
        eof_nxt   = 1'b0;
        data_nxt  = data_q;
`ifdef PKFB_TIMESTAMP_EN
        seq_nxt   = seq;
`endif
        case (eff_state)
            IDLE: begin
`ifdef PKFB_TIMESTAMP_EN
                if (enable && s_valid) begin
                    push_nxt  = 1'b1;
                    sof_nxt   = 1'b1;
                    data_nxt  = {seq, TimeStamp};
                    seq_nxt   = seq + 8'd1;
                    state_nxt = HDR;
                    cnt_nxt   = 16'd0;
                end
`else
                if (accept) begin
                    push_nxt  = 1'b1;
                    sof_nxt   = 1'b1;
                    eof_nxt   = SINGLE;
                    data_nxt  = s_data;
                    state_nxt = SINGLE ? IDLE : ACTIVE;
                    cnt_nxt   = SINGLE ? 16'd0 : 16'd1;
                end
`endif
            end
`ifdef PKFB_TIMESTAMP_EN
            HDR,
`endif
            ACTIVE: begin
                state_nxt = ACTIVE;
                if (accept) begin
                    push_nxt = 1'b1;
                    data_nxt = s_data;
                    if (is_last) begin
                        eof_nxt   = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = 16'd0;
                    end else begin
                        cnt_nxt   = word_cnt + 16'd1;
                    end
                end
            end
            DISCARD: begin
                state_nxt = DISCARD;
                if (accept) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 16'd0;
                    end else begin
                        cnt_nxt   = word_cnt + 16'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // FSM, word counter and registered push-side outputs.
    always_ff @(posedge Sys_PKfb_Clk or negedge Sys_PKfb_Rst_n) begin
        if (!Sys_PKfb_Rst_n) begin
            state    <= IDLE;
            word_cnt <= 16'd0;
            push_q   <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            data_q   <= 32'd0;
        end else begin
            state    <= state_nxt;
            word_cnt <= cnt_nxt;
            push_q   <= push_nxt;
            sof_q    <= sof_nxt;
            eof_q    <= eof_nxt;
            data_q   <= data_nxt;
        end
    end

`ifdef PKFB_TIMESTAMP_EN
    // Header sequence number, advanced once per header pushed.
    always_ff @(posedge Sys_PKfb_Clk or negedge Sys_PKfb_Rst_n) begin
        if (!Sys_PKfb_Rst_n) begin
            seq <= 8'd0;
        end else begin
            seq <= seq_nxt;
        end
    end
`endif

    // Status: sticky overflow (set beats clear), good-packet and drop counters.
    always_ff @(posedge Sys_PKfb_Clk or negedge Sys_PKfb_Rst_n) begin
        if (!Sys_PKfb_Rst_n) begin
            ovf_sticky <= 1'b0;
            pkt_cnt    <= 16'd0;
            drop_cnt   <= 16'd0;
        end else begin
            if (ovf_hit) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (push_q && eof_q && !FB_PKfbOverflow) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_pkfb_packetizer.sv
// Bench for pkfb_packetizer: two instances (4-word frames on push bit 2,
// 1-word frames on push bit 0) share one stimulus stream and are checked
// every cycle against a frame-position reference model.
module tb_pkfb_packetizer;

    localparam int LEN_A = 4;
    localparam int CH_A  = 2;
    localparam int LEN_B = 1;
    localparam int CH_B  = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        ovf = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [23:0] ts = 24'd0;

    logic        rdy_a, sof_a, eof_a, sticky_a;
    logic [31:0] data_a;
    logic [3:0]  push_a;
    logic [15:0] pkt_a, drop_a;
    logic        rdy_b, sof_b, eof_b, sticky_b;
    logic [31:0] data_b;
    logic [3:0]  push_b;
    logic [15:0] pkt_b, drop_b;

    always #5 clk = ~clk;

    pkfb_packetizer #(.PKT_LEN(LEN_A), .PUSH_CH(CH_A)) dut_a (
        .Sys_PKfb_Clk(clk), .Sys_PKfb_Rst_n(rst_n), .enable(enable),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_a),
        .FB_PKfbData(data_a), .FB_PKfbPush(push_a), .FB_PKfbSOF(sof_a),
        .FB_PKfbEOF(eof_a), .FB_PKfbOverflow(ovf),
`ifdef PKFB_TIMESTAMP_EN
        .TimeStamp(ts),
`endif
        .ovf_clr(ovf_clr), .ovf_sticky(sticky_a), .pkt_cnt(pkt_a), .drop_cnt(drop_a)
    );

    pkfb_packetizer #(.PKT_LEN(LEN_B), .PUSH_CH(CH_B)) dut_b (
        .Sys_PKfb_Clk(clk), .Sys_PKfb_Rst_n(rst_n), .enable(enable),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_b),
        .FB_PKfbData(data_b), .FB_PKfbPush(push_b), .FB_PKfbSOF(sof_b),
        .FB_PKfbEOF(eof_b), .FB_PKfbOverflow(ovf),
`ifdef PKFB_TIMESTAMP_EN
        .TimeStamp(ts),
`endif
        .ovf_clr(ovf_clr), .ovf_sticky(sticky_b), .pkt_cnt(pkt_b), .drop_cnt(drop_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: where we are inside the current frame, plus what the FIFO
    // side should show after the next clock edge.
    typedef struct {
        bit        in_pkt;
        bit        disc;
        int        pos;
        bit        push;
        bit        sof;
        bit        eof;
        bit [31:0] data;
        int        pkt;
        int        drop;
        bit        sticky;
        bit [7:0]  seq;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.in_pkt = 0; m.disc = 0; m.pos = 0; m.push = 0; m.sof = 0; m.eof = 0;
        m.data = 32'd0; m.pkt = 0; m.drop = 0; m.sticky = 0; m.seq = 8'd0;
        return m;
    endfunction

    function automatic bit mdl_ready(input mdl_t m, input bit en);
`ifdef PKFB_TIMESTAMP_EN
        return m.in_pkt;
`else
        return m.in_pkt || en;
`endif
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int len, input bit en, input bit sv,
                                      input bit [31:0] sd, input bit ov, input bit clr,
                                      input bit [23:0] tstamp);
        mdl_t n;
        bit hit;
        bit acc;
        n = m;
        hit = m.push && ov;
        acc = sv && mdl_ready(m, en);
        n.push = 0; n.sof = 0; n.eof = 0;
        if (hit) begin
            n.drop = n.drop + 1;
            n.sticky = 1;
            if (!m.eof) n.disc = 1;
        end else if (clr) begin
            n.sticky = 0;
        end
        if (m.push && m.eof && !ov) n.pkt = (m.pkt + 1) % 65536;
`ifdef PKFB_TIMESTAMP_EN
        if (!m.in_pkt && en && sv) begin
            n.push = 1; n.sof = 1; n.data = {m.seq, tstamp};
            n.seq = m.seq + 8'd1; n.in_pkt = 1; n.pos = 0;
        end
`endif
        if (acc) begin
            if (n.disc) begin
                n.drop = n.drop + 1;
            end else begin
                n.push = 1; n.data = sd; n.sof = !m.in_pkt; n.eof = (m.pos + 1 == len);
            end
            if (m.pos + 1 == len) begin
                n.in_pkt = 0; n.pos = 0; n.disc = 0;
            end else begin
                n.in_pkt = 1; n.pos = m.pos + 1;
            end
        end
        if (n.drop > 65535) n.drop = 65535;
        return n;
    endfunction

    task automatic cmp_out(input string who, input mdl_t m, input int ch, input logic [31:0] d,
                           input logic [3:0] p, input logic sof, input logic eof, input logic st,
                           input logic [15:0] pc, input logic [15:0] dc);
        chk_eq({who, "_push"}, {28'd0, p}, m.push ? (32'd1 << ch) : 32'd0);
        chk_eq({who, "_data"}, d, m.data);
        chk_eq({who, "_sof"}, {31'd0, sof}, {31'd0, m.sof});
        chk_eq({who, "_eof"}, {31'd0, eof}, {31'd0, m.eof});
        chk_eq({who, "_sticky"}, {31'd0, st}, {31'd0, m.sticky});
        chk_eq({who, "_pkt_cnt"}, {16'd0, pc}, m.pkt);
        chk_eq({who, "_drop_cnt"}, {16'd0, dc}, m.drop);
    endtask

    task automatic cmp_all();
        cmp_out("a", ma, CH_A, data_a, push_a, sof_a, eof_a, sticky_a, pkt_a, drop_a);
        cmp_out("b", mb, CH_B, data_b, push_b, sof_b, eof_b, sticky_b, pkt_b, drop_b);
    endtask

    // One clock: drive inputs just after an edge, check ready, advance the
    // model, then check the registered outputs just after the next edge.
    task automatic do_cycle(input bit en, input bit sv, input bit [31:0] sd, input bit ov, input bit clr);
        enable = en; s_valid = sv; s_data = sd; ovf = ov; ovf_clr = clr;
        ts = 24'($urandom);
        #1;
        chk_eq("a_ready", {31'd0, rdy_a}, {31'd0, mdl_ready(ma, en)});
        chk_eq("b_ready", {31'd0, rdy_b}, {31'd0, mdl_ready(mb, en)});
        ma = mdl_step(ma, LEN_A, en, sv, sd, ov, clr, ts);
        mb = mdl_step(mb, LEN_B, en, sv, sd, ov, clr, ts);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_all();
        rst_n = 1'b1;

        // Back-to-back frames with constant valid.
        for (int i = 0; i < 8; i++) do_cycle(1, 1, 32'h10 + 32'(i), 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
`ifndef PKFB_TIMESTAMP_EN
        chk_eq("tp1_pkt_a", {16'd0, pkt_a}, 32'd2);
        chk_eq("tp1_pkt_b", {16'd0, pkt_b}, 32'd8);
`endif

        // Overflow on the second word of a frame.
        do_cycle(1, 1, 32'h20, 0, 0);
        do_cycle(1, 1, 32'h21, 0, 0);
        do_cycle(1, 1, 32'h22, 1, 0);
        do_cycle(1, 1, 32'h23, 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
`ifndef PKFB_TIMESTAMP_EN
        chk_eq("tp2_drop_a", {16'd0, drop_a}, 32'd3);
        chk_eq("tp2_sticky_a", {31'd0, sticky_a}, 32'd1);
        chk_eq("tp2_pkt_a", {16'd0, pkt_a}, 32'd2);
`endif
        for (int i = 0; i < 4; i++) do_cycle(1, 1, 32'h30 + 32'(i), 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);

        // Gaps inside a frame.
        do_cycle(1, 1, 32'h40, 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
        do_cycle(1, 1, 32'h41, 0, 0);
        do_cycle(1, 1, 32'h42, 0, 0);
        do_cycle(1, 1, 32'h43, 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
`ifndef PKFB_TIMESTAMP_EN
        chk_eq("tp3_pkt_a", {16'd0, pkt_a}, 32'd4);
        chk_eq("tp3_pkt_b", {16'd0, pkt_b}, 32'd19);
`endif

        // Enable dropped mid-frame: frame completes, then nothing more.
        do_cycle(1, 1, 32'h50, 0, 0);
        do_cycle(1, 1, 32'h51, 0, 0);
        for (int i = 2; i < 6; i++) do_cycle(0, 1, 32'h50 + 32'(i), 0, 0);
        do_cycle(0, 0, 32'h0, 0, 0);
        chk_eq("tp4_ready_a", {31'd0, rdy_a}, 32'd0);

        // Overflow clear on its own.
        do_cycle(0, 0, 32'h0, 0, 1);

        // Reset in the middle of a frame.
        do_cycle(1, 1, 32'h60, 0, 0);
        do_cycle(1, 1, 32'h61, 0, 0);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        cmp_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle(1, 1, 32'h70 + 32'(i), 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);
        do_cycle(1, 0, 32'h0, 0, 0);

        // Random traffic with overflow and clear pulses.
        for (int i = 0; i < 4000; i++) begin
            do_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
